dmvm_stream: RTL and testbench

Parametrised, streaming successor to the GAT dense matrix-vector (DMVM) attention-coefficient unit. It reads packed Wh rows from the dual-read WH BRAM and, per subgraph, computes e_ij = a[0:F-1]·Wh_i + a[F:2F-1]·Wh_j for the source node i and every row j of that subgraph. Coefficients leave on a valid/ready stream with a last-of-subgraph marker, behind an internal credit-managed FIFO, instead of as a fixed output array. It sits between the Wh BRAM and the softmax stage, and adds signed arithmetic, an optional LeakyReLU, backpressure and error flagging.

---
 rtl/dmvm_pkg.sv | 22 ++
 rtl/dmvm_fifo.sv | 46 ++++
 rtl/dmvm_stream.sv | 223 ++++++++++++++++++++++
 tb/tb_dmvm_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmvm_pkg.sv
// Shared types and layout helpers for the streaming DMVM attention-coefficient unit.
package dmvm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int SRC_FLAG_BIT  = 0;
  localparam int NUM_NODES_LSB = 1;

  function automatic int sum_width(input int dw, input int nf);
    return 2 * dw + $clog2(2 * nf);
  endfunction

  function automatic int wh_bram_width(input int dw, input int nf, input int nnw);
    return dw * nf + nnw + 1;
  endfunction

  // Feature 0 sits in the most-significant slot of the row.
  function automatic int feat_lsb(input int k, input int dw, input int nf, input int nnw);
    return nnw + 1 + (nf - 1 - k) * dw;
  endfunction

endpackage

// File: rtl/dmvm_fifo.sv
// First-word fall-through FIFO; the count output feeds the read-credit check upstream.
module dmvm_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_valid,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push    = i_wr_en && (r_cnt != (AW+1)'(DEPTH));
  assign w_pop     = i_rd_en && (r_cnt != '0);
  assign o_valid   = (r_cnt != '0);
  assign o_rd_data = r_mem[r_rp];
  assign o_count   = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/dmvm_stream.sv
// Streaming GAT attention-coefficient unit: reads packed Wh rows, emits e_ij per row
// on a valid/ready stream behind a credit-managed output FIFO.
module dmvm_stream
  import dmvm_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_FEATURES    = 16,
  parameter int NUM_OF_NODES    = 168,
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int LEAKY_SHIFT     = 2,
  localparam int NUM_NODE_WIDTH = $clog2(NUM_OF_NODES),
  localparam int WH_BRAM_WIDTH  = wh_bram_width(DATA_WIDTH, NUM_FEATURES, NUM_NODE_WIDTH),
  localparam int SUM_WIDTH      = sum_width(DATA_WIDTH, NUM_FEATURES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [BRAM_ADDR_WIDTH-1:0]  num_rows_i,
  input  logic                        leaky_en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i [2*NUM_FEATURES],
  output logic                        WH_BRAM_enb,
  output logic [BRAM_ADDR_WIDTH-1:0]  WH_BRAM_addrb,
  input  logic [WH_BRAM_WIDTH-1:0]    WH_BRAM_dout,
  output logic signed [SUM_WIDTH-1:0] coef_o,
  output logic                        coef_valid_o,
  output logic                        coef_last_o,
  input  logic                        coef_ready_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int DW  = DATA_WIDTH;
  localparam int NF  = NUM_FEATURES;
  localparam int NNW = NUM_NODE_WIDTH;
  localparam int SW  = SUM_WIDTH;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int AW  = BRAM_ADDR_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int OW  = CW + 1;

  state_t               r_state;
  logic [AW-1:0]        r_num_rows;
  logic [AW-1:0]        r_addr;
  logic                 r_leaky;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic                 r_rd_v;
  logic                 r_p_v;
  logic                 r_c_v;
  logic signed [PW-1:0] r_p1 [NF];
  logic signed [PW-1:0] r_p2 [NF];
  logic                 r_p_src;
  logic [NNW-1:0]       r_p_nn;

  logic signed [SW-1:0] r_src_score;
  logic [NNW-1:0]       r_nn;
  logic [NNW-1:0]       r_next_idx;
  logic                 r_expect_src;
  logic signed [SW-1:0] r_coef;
  logic                 r_c_last;

  logic signed [DW-1:0] w_feat [NF];
  logic signed [SW-1:0] w_dot1;
  logic signed [SW-1:0] w_dot2;
  logic signed [SW-1:0] w_score;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_coef;
  logic [NNW-1:0]       w_idx;
  logic [NNW-1:0]       w_nn;
  logic                 w_last;
  logic                 w_fmt_err;

  logic [SW:0]          w_fifo_data;
  logic                 w_fifo_valid;
  logic [CW-1:0]        w_fifo_cnt;
  logic                 w_pop;
  logic [OW-1:0]        w_occ;
  logic                 w_issue;
  logic                 w_start;

  assign w_start = (r_state == IDLE) && start_i;
  assign w_pop   = coef_valid_o && coef_ready_i;

  // A pop this cycle frees its slot in time for the new read, keeping 1 row/cycle.
  assign w_occ   = OW'(w_fifo_cnt) + OW'(r_rd_v) + OW'(r_p_v) + OW'(r_c_v) - OW'(w_pop);
  assign w_issue = !rst && (r_state == RUN) && (w_occ < OW'(FIFO_DEPTH));

  assign WH_BRAM_enb   = w_issue;
  assign WH_BRAM_addrb = w_issue ? r_addr : '0;

  assign coef_valid_o = w_fifo_valid && !rst;
  assign coef_o       = coef_valid_o ? $signed(w_fifo_data[SW:1]) : '0;
  assign coef_last_o  = coef_valid_o && w_fifo_data[0];
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign err_o        = r_err;

  always_comb begin
    for (int unsigned k = 0; k < NF; k++) begin
      w_feat[k] = WH_BRAM_dout[feat_lsb(int'(k), DW, NF, NNW) +: DW];
    end
  end

  always_comb begin
    w_dot1 = '0;
    w_dot2 = '0;
    for (int unsigned k = 0; k < NF; k++) begin
      w_dot1 = w_dot1 + SW'(r_p1[k]);
      w_dot2 = w_dot2 + SW'(r_p2[k]);
    end
    w_idx     = r_p_src ? '0 : r_next_idx;
    w_nn      = r_p_src ? r_p_nn : r_nn;
    w_last    = (w_idx == w_nn - NNW'(1));
    w_score   = r_p_src ? w_dot1 : r_src_score;
    w_sum     = w_score + w_dot2;
    w_coef    = (r_leaky && w_sum[SW-1]) ? (w_sum >>> LEAKY_SHIFT) : w_sum;
    w_fmt_err = r_p_v && (r_p_src != r_expect_src);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_v       <= 1'b0;
      r_p_v        <= 1'b0;
      r_c_v        <= 1'b0;
      r_src_score  <= '0;
      r_nn         <= '0;
      r_next_idx   <= '0;
      r_expect_src <= 1'b1;
    end else begin
      r_rd_v <= w_issue;
      r_p_v  <= r_rd_v;
      r_c_v  <= r_p_v;
      for (int unsigned k = 0; k < NF; k++) begin
        r_p1[k] <= PW'(a_i[k]) * PW'(w_feat[k]);
        r_p2[k] <= PW'(a_i[NF+k]) * PW'(w_feat[k]);
      end
      r_p_src <= WH_BRAM_dout[SRC_FLAG_BIT];
      r_p_nn  <= WH_BRAM_dout[NUM_NODES_LSB +: NNW];
      if (r_p_v) begin
        r_coef       <= w_coef;
        r_c_last     <= w_last;
        r_next_idx   <= w_last ? '0 : w_idx + NNW'(1);
        r_expect_src <= w_last;
        if (r_p_src) begin
          r_src_score <= w_dot1;
          r_nn        <= r_p_nn;
        end
      end
      if (w_start) begin
        r_next_idx   <= '0;
        r_expect_src <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_num_rows <= '0;
      r_addr     <= '0;
      r_leaky    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fmt_err) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_busy     <= 1'b1;
            r_err      <= 1'b0;
            r_num_rows <= num_rows_i;
            r_leaky    <= leaky_en_i;
            r_addr     <= '0;
            if (num_rows_i == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            if (r_addr == r_num_rows - AW'(1)) r_state <= DRAIN;
            else                               r_addr  <= r_addr + AW'(1);
          end
        end
        DRAIN: begin
          if (w_occ == '0) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  dmvm_fifo #(
    .WIDTH (SW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_c_v),
    .i_wr_data ({r_coef, r_c_last}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_valid   (w_fifo_valid),
    .o_count   (w_fifo_cnt)
  );

endmodule

// File: tb/tb_dmvm_stream.sv
// Scoreboard bench for dmvm_stream: a behavioural model queues expected coefficients per job.
module tb_dmvm_stream;

  localparam int DW  = 8;
  localparam int NF  = 16;
  localparam int NNW = 8;
  localparam int AW  = 32;
  localparam int FD  = 4;
  localparam int LS  = 2;
  localparam int SW  = 2 * DW + 5;
  localparam int WBW = DW * NF + NNW + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start_i;
  logic [AW-1:0]         num_rows_i;
  logic                  leaky_en_i;
  logic signed [DW-1:0]  a_tb [2*NF];
  logic                  WH_BRAM_enb;
  logic [AW-1:0]         WH_BRAM_addrb;
  logic [WBW-1:0]        WH_BRAM_dout;
  logic signed [SW-1:0]  coef_o;
  logic                  coef_valid_o;
  logic                  coef_last_o;
  logic                  coef_ready_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  always #5 clk = ~clk;

  dmvm_stream #(
    .DATA_WIDTH      (DW),
    .NUM_FEATURES    (NF),
    .NUM_OF_NODES    (168),
    .BRAM_ADDR_WIDTH (AW),
    .FIFO_DEPTH      (FD),
    .LEAKY_SHIFT     (LS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .num_rows_i    (num_rows_i),
    .leaky_en_i    (leaky_en_i),
    .a_i           (a_tb),
    .WH_BRAM_enb   (WH_BRAM_enb),
    .WH_BRAM_addrb (WH_BRAM_addrb),
    .WH_BRAM_dout  (WH_BRAM_dout),
    .coef_o        (coef_o),
    .coef_valid_o  (coef_valid_o),
    .coef_last_o   (coef_last_o),
    .coef_ready_i  (coef_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  logic [WBW-1:0] mem [16];
  int             rf [16][NF];
  bit             rsrc [16];
  int             rnn [16];

  always @(posedge clk) if (WH_BRAM_enb) WH_BRAM_dout <= mem[WH_BRAM_addrb[3:0]];

  typedef struct { longint coef; bit last; } exp_t;
  exp_t   sb[$];
  exp_t   sb_e;
  int     n_chk = 0;
  int     n_err = 0;
  longint m_score = 0;
  int     m_nn = 0;
  int     issued = 0;
  int     xfers = 0;
  int     max_out = 0;
  longint t_last_xfer = 0;

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      issued = 0;
      xfers  = 0;
    end else begin
      if (WH_BRAM_enb) issued++;
      if (coef_valid_o && coef_ready_i) begin
        xfers++;
        t_last_xfer = $time;
        if (sb.size() == 0) check_val("extra_coef", 1, 0);
        else begin
          sb_e = sb.pop_front();
          check_val("coef", longint'(coef_o), sb_e.coef);
          check_val("last", longint'(coef_last_o), longint'(sb_e.last));
        end
      end
      if (issued - xfers > max_out) max_out = issued - xfers;
    end
  end

  task automatic set_row(input int r, input bit src, input int nn, input int w);
    rsrc[r] = src;
    rnn[r]  = nn;
    for (int k = 0; k < NF; k++) rf[r][k] = w;
  endtask

  task automatic pack_rows(input int n);
    logic [WBW-1:0] row;
    logic [DW-1:0]  fv;
    logic [NNW-1:0] nv;
    for (int r = 0; r < n; r++) begin
      row = '0;
      row[0] = rsrc[r];
      nv = rnn[r][NNW-1:0];
      row[NNW:1] = nv;
      for (int k = 0; k < NF; k++) begin
        fv = rf[r][k][DW-1:0];
        row[NNW + 1 + (NF - 1 - k) * DW +: DW] = fv;
      end
      mem[r] = row;
    end
  endtask

  task automatic model_job(input int n, input bit leaky, output bit err);
    bit     exp_src = 1'b1;
    int     idx = 0;
    longint d1, d2, c;
    bit     last;
    err = 1'b0;
    for (int r = 0; r < n; r++) begin
      d1 = 0;
      d2 = 0;
      for (int k = 0; k < NF; k++) begin
        d1 += longint'(a_tb[k]) * rf[r][k];
        d2 += longint'(a_tb[NF + k]) * rf[r][k];
      end
      if (rsrc[r]) begin
        if (!exp_src) err = 1'b1;
        m_score = d1;
        m_nn    = rnn[r];
        idx     = 0;
      end else if (exp_src) begin
        err = 1'b1;
      end
      c = m_score + d2;
      c = (c <<< (64 - SW)) >>> (64 - SW);
      if (leaky && c < 0) c = c >>> LS;
      last = (idx == ((m_nn - 1) & ((1 << NNW) - 1)));
      sb.push_back('{coef: c, last: last});
      exp_src = last;
      idx = last ? 0 : idx + 1;
    end
  endtask

  task automatic run_job(input int n, input bit leaky, input bit stall, input string name);
    bit exp_err;
    bit seen = 1'b0;
    int cyc = 0;
    pack_rows(n);
    model_job(n, leaky, exp_err);
    @(posedge clk) #1;
    start_i = 1'b1; num_rows_i = AW'(n); leaky_en_i = leaky; coef_ready_i = 1'b1;
    @(posedge clk) #1;
    start_i = 1'b0;
    check_val({name, "_busy_rise"}, longint'(busy_o), 1);
    check_val({name, "_err_clr"}, longint'(err_o), 0);
    while (!seen && cyc < 3000) begin
      if (done_o) seen = 1'b1;
      else begin
        coef_ready_i = !(stall && cyc >= 5 && cyc <= 25);
        start_i      = (cyc == 10);
        num_rows_i   = (cyc == 10) ? AW'(3) : AW'(n);
        @(posedge clk) #1;
        cyc++;
      end
    end
    start_i = 1'b0;
    coef_ready_i = 1'b1;
    check_val({name, "_done"}, longint'(seen), 1);
    if (!stall) begin
      check_val({name, "_cycles"}, cyc, (n == 0) ? 0 : n + 4);
      if (n > 0) check_val({name, "_done_after_xfer"}, longint'($time - t_last_xfer), 6);
    end
    check_val({name, "_err"}, longint'(err_o), longint'(exp_err));
    check_val({name, "_sb_left"}, sb.size(), 0);
    @(posedge clk) #1;
    check_val({name, "_done_pulse"}, longint'(done_o), 0);
    check_val({name, "_busy_fall"}, longint'(busy_o), 0);
  endtask

  task automatic nominal_setup();
    int ws[10] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 1};
    for (int k = 0; k < NF; k++) begin
      a_tb[k] = 8'sd2;
      a_tb[NF + k] = 8'sd3;
    end
    for (int r = 0; r < 10; r++) set_row(r, (r == 0 || r == 5), 5, ws[r]);
  endtask

  task automatic check_outs_zero(input string tag);
    check_val(tag, longint'({WH_BRAM_enb, coef_valid_o, coef_last_o, busy_o, done_o, err_o,
                             |coef_o, |WH_BRAM_addrb}), 0);
  endtask

  initial begin
    int  i0;
    bit  found;
    int  ws_mid[7] = '{1, 2, 3, 4, 5, 1, 2};
    rst = 1'b1; start_i = 1'b0; num_rows_i = '0; leaky_en_i = 1'b0; coef_ready_i = 1'b1;
    for (int k = 0; k < 2 * NF; k++) a_tb[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outs_zero("reset_outs");
    rst = 1'b0;

    nominal_setup();
    run_job(10, 1'b0, 1'b0, "nominal");

    for (int k = 0; k < 2 * NF; k++) a_tb[k] = -8'sd1;
    set_row(0, 1'b1, 1, 1);
    run_job(1, 1'b1, 1'b0, "leaky_on");
    run_job(1, 1'b0, 1'b0, "leaky_off");

    i0 = issued;
    run_job(0, 1'b0, 1'b0, "zero_rows");
    check_val("zero_rows_no_enb", issued - i0, 0);

    nominal_setup();
    max_out = 0;
    run_job(10, 1'b0, 1'b1, "backpressure");
    check_val("backpressure_max_outstanding", max_out, FD);

    set_row(0, 1'b0, 5, 1);
    set_row(1, 1'b1, 2, 2);
    set_row(2, 1'b0, 2, 3);
    run_job(3, 1'b0, 1'b0, "no_src_first");

    nominal_setup();
    run_job(10, 1'b0, 1'b0, "nominal2");

    for (int r = 0; r < 7; r++) set_row(r, (r == 0 || r == 2), 5, ws_mid[r]);
    run_job(7, 1'b0, 1'b0, "mid_src");

    for (int k = 0; k < 2 * NF; k++) a_tb[k] = DW'($urandom_range(255));
    for (int r = 0; r < 6; r++) begin
      rsrc[r] = (r == 0);
      rnn[r]  = 6;
      for (int k = 0; k < NF; k++) rf[r][k] = int'($urandom_range(255)) - 128;
    end
    run_job(6, 1'b1, 1'b0, "random");

    nominal_setup();
    pack_rows(10);
    @(posedge clk) #1;
    coef_ready_i = 1'b0; start_i = 1'b1; num_rows_i = AW'(10); leaky_en_i = 1'b0;
    @(posedge clk) #1;
    start_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (WH_BRAM_enb && WH_BRAM_addrb == AW'(3)) found = 1'b1;
      else @(posedge clk) #1;
    end
    check_val("reset_reach_row3", longint'(found), 1);
    rst = 1'b1;
    @(posedge clk) #1;
    check_outs_zero("midjob_reset_outs_a");
    @(posedge clk) #1;
    check_outs_zero("midjob_reset_outs_b");
    rst = 1'b0;
    coef_ready_i = 1'b1;
    sb.delete();
    m_score = 0;
    m_nn = 0;
    run_job(10, 1'b0, 1'b0, "after_reset");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
